// File: rtl/strobe_period_meter.sv
// Measures the distance in clk cycles between successive rising edges of a strobe
// and hands each result out over valid/ready, with sticky overrun and timeout flags.
module strobe_period_meter #(
    parameter int CNT_BITS   = 16,
    parameter int MAX_PERIOD = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                strobe,
    input  logic                clear,
    output logic [CNT_BITS-1:0] period,
    output logic                valid,
    input  logic                ready,
    output logic                overrun,
    output logic                timeout
);

    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_PERIOD);
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic                strobe_d;
    logic                rise;
    logic                res_fire;

    assign rise     = strobe & ~strobe_d;
    assign res_fire = (state == MEASURE) && rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            strobe_d <= 1'b0;
            period   <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // strobe_d tracks the input even during clear, so a level held
            // across clear is not mistaken for a fresh edge afterwards
            strobe_d <= strobe;
            if (clear) begin
                state   <= IDLE;
                cnt     <= '0;
                period  <= '0;
                valid   <= 1'b0;
                overrun <= 1'b0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            cnt   <= ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            cnt <= ONE;
                        end else if (cnt == MAX_CNT) begin
                            timeout <= 1'b1;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase

                if (res_fire) begin
                    period <= cnt;
                    valid  <= 1'b1;
                    if (valid && !ready)
                        overrun <= 1'b1;
                end else if (valid && ready) begin
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_strobe_period_meter.sv
// Directed and randomized checks of strobe_period_meter against a timestamp-based
// reference model (periods are differences of edge cycle numbers).
module tb_strobe_period_meter;

    localparam int CNT_BITS   = 16;
    localparam int MAX_PERIOD = 20;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                strobe = 1'b0;
    logic                clear = 1'b0;
    logic                ready = 1'b0;
    logic [CNT_BITS-1:0] period;
    logic                valid;
    logic                overrun;
    logic                timeout;

    strobe_period_meter #(.CNT_BITS(CNT_BITS), .MAX_PERIOD(MAX_PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .strobe(strobe), .clear(clear),
        .period(period), .valid(valid), .ready(ready),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: remembers the cycle number of the last rising edge
    int     now;
    int     last_edge;
    bit     measuring;
    bit     m_prev;
    int     m_period;
    bit     m_valid;
    bit     m_ovr;
    bit     m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; measuring = 0; m_period = 0;
        m_valid = 0; m_ovr = 0; m_to = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit r);
        bit e;
        bit fire;
        int res;
        now++;
        e = s & ~m_prev;
        m_prev = s;
        fire = 0;
        res = 0;
        if (c) begin
            model_reset();
            m_prev = s;
        end else begin
            if (e) begin
                if (measuring) begin
                    fire = 1;
                    res = now - last_edge;
                end
                measuring = 1;
                last_edge = now;
            end else if (measuring && (now - last_edge) == MAX_PERIOD) begin
                m_to = 1;
                measuring = 0;
            end
            if (fire) begin
                if (m_valid && !r) m_ovr = 1;
                m_period = res;
                m_valid = 1;
            end else if (m_valid && r) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("period", 32'(period), 32'(m_period));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    // called at a negedge: drive, clock, update model, check at next negedge
    task automatic cycle(input bit s, input bit c, input bit r);
        strobe = s; clear = c; ready = r;
        @(posedge clk);
        model_step(s, c, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic train(input int pulses, input int per, input int hi, input bit r);
        for (int p = 0; p < pulses; p++)
            for (int k = 0; k < per; k++)
                cycle(k < hi, 1'b0, r);
    endtask

    task automatic do_clear();
        cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        now = 0;
        last_edge = 0;
        model_reset();
        #12;
        chk("reset_period", 32'(period), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_flags", {30'd0, overrun, timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-cycle pulses every 5 cycles, always ready
        train(4, 5, 1, 1'b1);
        chk("p5_ready_period", 32'(period), 5);
        chk("p5_ready_ovr", 32'(overrun), 0);

        // same pulses, never ready
        do_clear();
        train(4, 5, 1, 1'b0);
        chk("p5_hold_period", 32'(period), 5);
        chk("p5_hold_valid", 32'(valid), 1);
        chk("p5_hold_ovr", 32'(overrun), 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("accept_valid", 32'(valid), 0);
        chk("accept_ovr", 32'(overrun), 1);

        // timeout exactly MAX_PERIOD cycles after the edge sample
        do_clear();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MAX_PERIOD - 1; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("to_early", 32'(timeout), 0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("to_set", 32'(timeout), 1);
        chk("to_novalid", 32'(valid), 0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("after_to_period", 32'(period), 7);
        chk("after_to_sticky", 32'(timeout), 1);

        // long high level counts only its rise; then toggling every cycle
        do_clear();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        chk("level_period", 32'(period), 13);
        train(6, 2, 1, 1'b1);
        chk("toggle_period", 32'(period), 2);

        // clear coincident with an edge while valid and overrun are set
        do_clear();
        train(3, 4, 1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("pre_clear_ovr", 32'(overrun), 1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("clr_valid", 32'(valid), 0);
        chk("clr_period", 32'(period), 0);
        chk("clr_flags", {30'd0, overrun, timeout}, 0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("post_clr_period", 32'(period), 6);
        chk("post_clr_ovr", 32'(overrun), 0);

        // async reset mid-measurement, strobe high at release
        train(2, 4, 1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_period", 32'(period), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_flags", {30'd0, overrun, timeout}, 0);
        model_reset();
        strobe = 1'b1;
        #1 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("rel_period", 32'(period), 6);

        // randomized: varying strobe density, random ready, rare clears
        for (int blk = 0; blk < 40; blk++) begin
            int dens;
            dens = (blk % 7 == 3) ? 3 : int'($urandom_range(8, 60));
            for (int i = 0; i < 100; i++)
                cycle($urandom_range(0, 99) < dens, $urandom_range(0, 199) == 0,
                      $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/strobe_period_meter.md
Name: strobe_period_meter

Overview:
- Consumer end of the clock-enable strobe interface: takes a single-cycle (or longer) strobe, as produced by the clock prescaler, and measures the period between successive rising edges in clk cycles.
- Delivers each measurement over a valid/ready output with overrun and timeout flags.
- Used in self-test and bring-up to confirm refresh/scan strobe rates on the LED matrix before the display pipeline consumes them.

Parameters:
- CNT_BITS, 16, width of the period counter and of the period output.
- MAX_PERIOD, 65535, timeout limit in cycles; must fit in CNT_BITS bits and be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- strobe  in  1  synchronous strobe under measurement; only rising edges are significant.
- clear  in  1  synchronous clear: abort measurement, drop result, clear flags.
- period  out  CNT_BITS  last measured rise-to-rise distance in cycles.
- valid  out  1  period holds an unconsumed result.
- ready  in  1  consumer accepts period when valid & ready.
- overrun  out  1  sticky: a result was overwritten before being accepted.
- timeout  out  1  sticky: no edge within MAX_PERIOD cycles while measuring.

Behaviour:
- Reset (rst_n low, async): state IDLE, cnt=0, strobe_d=0, period=0, valid=0, overrun=0, timeout=0.
- Edge detect: edge = strobe & ~strobe_d; strobe_d <= strobe every cycle, including during clear.
  - Because strobe_d resets to 0, a strobe already high in the first cycle after reset release counts as an edge.
- States:
  - IDLE: on edge, cnt <= 1 and go to MEASURE. No result is produced.
  - MEASURE, edge: result = cnt; cnt <= 1; stay in MEASURE.
  - MEASURE, no edge and cnt == MAX_PERIOD: timeout <= 1, cnt <= 0, go to IDLE, no result.
  - MEASURE, otherwise: cnt <= cnt + 1.
- Period definition:
  - Edges at cycles t0 and t0+P give period = P.
  - A prescaler with terminal count N yields P = N+1.
  - Minimum measurable P = 2 (strobe toggling every cycle).
  - Strobe held high for many cycles counts only its rising edge.
- Output registers:
  - The result is registered: period and valid update on the clock edge at which the edge is sampled, so they are visible the following cycle. Latency from edge sample is 1 cycle.
  - valid & ready with no new result: valid <= 0 next cycle.
  - New result and (valid & ready) in the same cycle: period <= new, valid stays 1, no overrun.
  - New result while valid & ~ready: period <= new (overwrite), valid stays 1, overrun <= 1.
  - period is held while valid is low; it is not zeroed after acceptance.
- clear (highest priority after reset):
  - Next state IDLE, cnt=0, valid=0, period=0, overrun=0, timeout=0.
  - An edge in the same cycle as clear is ignored: no MEASURE entry.
- Flag priority: timeout and overrun are cleared only by clear or reset. If a new set condition coincides with clear, clear wins.
- Counter arithmetic is CNT_BITS wide and unsigned. The counter never wraps, because the timeout stops it at MAX_PERIOD.
- rst_n asserted mid-measurement: all state and outputs return to reset values immediately, with no clock needed.

Test Plan:
- Strobe 1-cycle pulse every 5 cycles, ready=1, 4 pulses -> 3 results, each period=5. valid high 1 cycle, 1 cycle after each 2nd+ edge sample; overrun=0, timeout=0.
- Same stimulus, ready=0 throughout -> valid stays 1; period=5 after last edge; overrun=1 after 2nd result. Then ready=1 for 1 cycle -> valid=0 next cycle, overrun still 1.
- MAX_PERIOD=20, one edge then strobe low -> timeout=1 exactly 20 cycles after the edge sample, state IDLE, no valid. Two further edges 7 cycles apart -> period=7, timeout still 1.
- Strobe high 10 cycles, low 3, high again -> period=13. Strobe toggling every cycle -> period=2 on each result.
- clear asserted in the same cycle as an edge, while valid=1 and overrun=1 -> next cycle valid=0, period=0, overrun=0, timeout=0. The coincident edge does not start a measurement: the next two edges P apart yield exactly one result.
- rst_n pulsed low mid-MEASURE between clock edges -> all outputs 0 before the next posedge. Strobe held high at reset release -> counts as first edge; next rise 6 cycles later gives period=6.
